// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arb_pkg : shared state encoding, grant ids and sizes for mem_arbiter
// Rev 1.0
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_ACC = 3'd1,
    I_ACC = 3'd2,
    I_GAP = 3'd3,
    RESP  = 3'd4
  } arb_state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam int BEATS_PER_IBLOCK = 4;
  localparam int BEAT_W           = $clog2(BEATS_PER_IBLOCK);
  localparam int BLK_AW           = 6;
  localparam int WORD_W           = 32;
  localparam int IBLK_W           = WORD_W * BEATS_PER_IBLOCK;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : cache refill ports plus the unified memory port
// Rev 1.0
// ============================================================================
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW = 9
);
  logic                imem_read;
  logic [BLK_AW-1:0]   imem_address;
  logic [IBLK_W-1:0]   imem_readdata;
  logic                imem_busywait;

  logic                mem_read;
  logic                mem_write;
  logic [BLK_AW-1:0]   mem_address;
  logic [WORD_W-1:0]   mem_writedata;
  logic [WORD_W-1:0]   mem_readdata;
  logic                mem_busywait;

  logic                umem_read;
  logic                umem_write;
  logic [MEM_AW-1:0]   umem_address;
  logic [WORD_W-1:0]   umem_writedata;
  logic [WORD_W-1:0]   umem_readdata;
  logic                umem_busywait;

  // Arbiter side
  modport master (
    input  imem_read, imem_address, mem_read, mem_write, mem_address, mem_writedata,
           umem_readdata, umem_busywait,
    output imem_readdata, imem_busywait, mem_readdata, mem_busywait,
           umem_read, umem_write, umem_address, umem_writedata
  );

  // Caches and memory side
  modport slave (
    output imem_read, imem_address, mem_read, mem_write, mem_address, mem_writedata,
           umem_readdata, umem_busywait,
    input  imem_readdata, imem_busywait, mem_readdata, mem_busywait,
           umem_read, umem_write, umem_address, umem_writedata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-requester round-robin picker; history advances on a grant
// Rev 1.0
// ============================================================================
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic       valid_o,
  output logic       gnt_o
);

  logic last_q, last_d;

  always_comb begin
    valid_o = |req_i;
    gnt_o   = GNT_I;
    if (req_i[GNT_I] && req_i[GNT_D]) begin
      gnt_o = ~last_q;
    end else if (req_i[GNT_D]) begin
      gnt_o = GNT_D;
    end
    last_d = last_q;
    if (adv_i && valid_o) begin
      last_d = gnt_o;
    end
  end

  // Reset history favours the dcache on the first tie
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= GNT_I;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one word memory between icache (4-beat) and dcache
// Rev 1.0
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW    = 9,
  parameter int DATA_BASE = 256
) (
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.master bus
);

  arb_state_t          state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                seen_busy_q, seen_busy_d;
  logic                grant_q, grant_d;
  logic                umem_read_q, umem_read_d;
  logic                umem_write_q, umem_write_d;
  logic [MEM_AW-1:0]   umem_addr_q, umem_addr_d;
  logic [WORD_W-1:0]   umem_wdata_q, umem_wdata_d;
  logic [IBLK_W-1:0]   irdata_q, irdata_d;
  logic [WORD_W-1:0]   drdata_q, drdata_d;

  logic                d_req;
  logic                arb_valid;
  logic                arb_gnt;
  logic                beat_done;
  logic [BEAT_W-1:0]   beat_next;
  logic [MEM_AW-1:0]   d_word_addr;

  function automatic logic [MEM_AW-1:0] iaddr(input logic [BLK_AW-1:0] blk,
                                              input logic [BEAT_W-1:0] beat);
    return MEM_AW'({blk, beat});
  endfunction

  assign d_req       = bus.mem_read | bus.mem_write;
  assign beat_next   = beat_q + 1'b1;
  assign d_word_addr = MEM_AW'(DATA_BASE) + MEM_AW'(bus.mem_address);

  rr_arb2 u_rr (
    .clk_i   (CLK),
    .rst_ni  (RESET),
    .req_i   ({d_req, bus.imem_read}),
    .adv_i   (state_q == IDLE),
    .valid_o (arb_valid),
    .gnt_o   (arb_gnt)
  );

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    seen_busy_d  = seen_busy_q;
    grant_d      = grant_q;
    umem_read_d  = umem_read_q;
    umem_write_d = umem_write_q;
    umem_addr_d  = umem_addr_q;
    umem_wdata_d = umem_wdata_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;
    beat_done    = seen_busy_q && !bus.umem_busywait;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d     = arb_gnt;
          seen_busy_d = 1'b0;
          if (arb_gnt == GNT_D) begin
            state_d      = D_ACC;
            umem_read_d  = bus.mem_read;
            umem_write_d = bus.mem_write;
            umem_addr_d  = d_word_addr;
            umem_wdata_d = bus.mem_writedata;
          end else begin
            state_d      = I_ACC;
            beat_d       = '0;
            umem_read_d  = 1'b1;
            umem_write_d = 1'b0;
            umem_addr_d  = iaddr(bus.imem_address, '0);
          end
        end
      end
      D_ACC, I_ACC: begin
        if (bus.umem_busywait) begin
          seen_busy_d = 1'b1;
        end
        // A beat only ends after the memory has shown at least one busy cycle
        if (beat_done) begin
          umem_read_d  = 1'b0;
          umem_write_d = 1'b0;
          if (state_q == D_ACC) begin
            if (umem_read_q) begin
              drdata_d = bus.umem_readdata;
            end
            state_d = RESP;
          end else begin
            irdata_d[{beat_q, 5'd0} +: WORD_W] = bus.umem_readdata;
            state_d = (beat_q == BEAT_W'(BEATS_PER_IBLOCK - 1)) ? RESP : I_GAP;
          end
        end
      end
      I_GAP: begin
        state_d     = I_ACC;
        beat_d      = beat_next;
        seen_busy_d = 1'b0;
        umem_read_d = 1'b1;
        umem_addr_d = iaddr(bus.imem_address, beat_next);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      seen_busy_q  <= 1'b0;
      grant_q      <= GNT_I;
      umem_read_q  <= 1'b0;
      umem_write_q <= 1'b0;
      umem_addr_q  <= '0;
      umem_wdata_q <= '0;
      irdata_q     <= '0;
      drdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      seen_busy_q  <= seen_busy_d;
      grant_q      <= grant_d;
      umem_read_q  <= umem_read_d;
      umem_write_q <= umem_write_d;
      umem_addr_q  <= umem_addr_d;
      umem_wdata_q <= umem_wdata_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
    end
  end

  assign bus.umem_read      = umem_read_q;
  assign bus.umem_write     = umem_write_q;
  assign bus.umem_address   = umem_addr_q;
  assign bus.umem_writedata = umem_wdata_q;
  assign bus.imem_readdata  = irdata_q;
  assign bus.mem_readdata   = drdata_q;

  // Busywait drops only for the granted requester during its RESP cycle
  assign bus.imem_busywait = bus.imem_read & ~((state_q == RESP) & (grant_q == GNT_I));
  assign bus.mem_busywait  = d_req         & ~((state_q == RESP) & (grant_q == GNT_D));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : randomized self-checking bench with a busy-N memory model
// Rev 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int   MEM_AW    = 9;
  localparam int   DATA_BASE = 256;
  localparam logic SRC_I     = 1'b0;
  localparam logic SRC_D     = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.MEM_AW(MEM_AW)) bus ();

  mem_arbiter #(.MEM_AW(MEM_AW), .DATA_BASE(DATA_BASE)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory model: busy for lat_n cycles after it sees a strobe
  logic [31:0] mm_mem  [0:511];
  logic [31:0] ref_mem [0:511];
  int          lat_n = 5;
  int          mm_cnt;
  logic        mm_busy, mm_done, mm_post;
  int          cyc = 0;
  int          log_addr[$];
  bit          log_wr[$];
  logic [31:0] log_wd[$];
  int          log_cyc[$];

  assign bus.umem_busywait = mm_busy;
  assign bus.umem_readdata = mm_mem[bus.umem_address];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      mm_busy <= 1'b0;
      mm_cnt  <= 0;
      mm_done <= 1'b0;
      mm_post <= 1'b0;
    end else begin
      mm_post <= mm_done;
      mm_done <= 1'b0;
      if (mm_post) chk("strobe_low_after_beat", {bus.umem_read, bus.umem_write}, 2'b00);
      if (mm_busy) begin
        if (mm_cnt == 1) begin
          mm_busy <= 1'b0;
          mm_done <= 1'b1;
          if (bus.umem_write) mm_mem[bus.umem_address] <= bus.umem_writedata;
        end
        mm_cnt <= mm_cnt - 1;
      end else if (!mm_done && (bus.umem_read || bus.umem_write)) begin
        mm_busy <= 1'b1;
        mm_cnt  <= lat_n;
        log_addr.push_back(int'(bus.umem_address));
        log_wr.push_back(bus.umem_write);
        log_wd.push_back(bus.umem_writedata);
        log_cyc.push_back(cyc);
      end
    end
  end

  // Reference state: last served requester and last dcache read word
  logic        ref_last = SRC_I;
  logic [31:0] ref_drd  = '0;

  function automatic logic [127:0] exp_blk(input logic [5:0] a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = ref_mem[4*a + k];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_d(input bit wr, input logic [5:0] a, input logic [31:0] wd, input bit chk_lat);
    int base, cycles;
    bit ok;
    base = log_addr.size(); cycles = 0; ok = 1'b0;
    bus.mem_read = !wr; bus.mem_write = wr; bus.mem_address = a; bus.mem_writedata = wd;
    #1;
    chk("d_busy_on_req", bus.mem_busywait, 1'b1);
    for (int i = 0; i < 300 && !ok; i++) begin
      tick(); cycles++;
      if (!bus.mem_busywait) ok = 1'b1;
    end
    chk("d_timeout", ok, 1'b1);
    if (ok) begin
      if (chk_lat) chk("d_latency", cycles, lat_n + 3);
      if (!wr) ref_drd = ref_mem[DATA_BASE + a];
      chk("d_readdata", bus.mem_readdata, ref_drd);
      chk("d_umem_count", log_addr.size() - base, 1);
      if (log_addr.size() > base) begin
        chk("d_umem_addr", log_addr[base], DATA_BASE + a);
        chk("d_umem_kind", log_wr[base], wr);
        if (wr) chk("d_umem_wdata", log_wd[base], wd);
      end
    end
    if (wr) ref_mem[DATA_BASE + a] = wd;
    ref_last = SRC_D;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    tick();
  endtask

  task automatic do_i(input logic [5:0] a, input bit hold);
    int base;
    bit ok;
    base = log_addr.size(); ok = 1'b0;
    bus.imem_read = 1'b1; bus.imem_address = a;
    #1;
    chk("i_busy_on_req", bus.imem_busywait, 1'b1);
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      if (!bus.imem_busywait) ok = 1'b1;
    end
    chk("i_timeout", ok, 1'b1);
    if (ok) begin
      chk("i_readdata", bus.imem_readdata, exp_blk(a));
      chk("i_beats", log_addr.size() - base, 4);
      for (int k = 0; k < 4 && base + k < log_addr.size(); k++) begin
        chk("i_beat_addr", log_addr[base + k], 4*a + k);
        chk("i_beat_kind", log_wr[base + k], 1'b0);
        if (k > 0) chk("i_beat_spacing", log_cyc[base + k] - log_cyc[base + k - 1], lat_n + 3);
      end
    end
    ref_last = SRC_I;
    if (hold) begin
      tick();
      chk("i_stale_busy", bus.imem_busywait, 1'b1);
    end
    bus.imem_read = 1'b0;
    repeat (3) tick();
    chk("i_no_reissue", log_addr.size() - base, 4);
  endtask

  task automatic do_tie(input logic [5:0] da, input logic [5:0] ia);
    bit d_ok, i_ok, first;
    logic exp_first;
    int base;
    d_ok = 1'b0; i_ok = 1'b0; first = 1'b0;
    exp_first = (ref_last == SRC_I) ? SRC_D : SRC_I;
    base = log_addr.size();
    bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mem_address = da;
    bus.imem_read = 1'b1; bus.imem_address = ia;
    #1;
    chk("tie_busy_both", {bus.mem_busywait, bus.imem_busywait}, 2'b11);
    for (int i = 0; i < 1200 && !(d_ok && i_ok); i++) begin
      tick();
      if (!d_ok && !bus.mem_busywait) begin
        if (!i_ok) begin
          first = SRC_D;
          chk("tie_loser_busy", bus.imem_busywait, 1'b1);
        end
        d_ok = 1'b1;
        ref_drd = ref_mem[DATA_BASE + da];
        chk("tie_d_readdata", bus.mem_readdata, ref_drd);
        bus.mem_read = 1'b0;
      end else if (!i_ok && !bus.imem_busywait) begin
        if (!d_ok) begin
          first = SRC_I;
          chk("tie_loser_busy", bus.mem_busywait, 1'b1);
        end
        i_ok = 1'b1;
        chk("tie_i_readdata", bus.imem_readdata, exp_blk(ia));
        bus.imem_read = 1'b0;
      end
    end
    chk("tie_timeout", d_ok & i_ok, 1'b1);
    chk("tie_order", first, exp_first);
    chk("tie_umem_count", log_addr.size() - base, 5);
    ref_last = ~exp_first;
    bus.mem_read = 1'b0; bus.imem_read = 1'b0;
    tick();
  endtask

  initial begin
    int base;
    bit ok;
    for (int w = 0; w < 512; w++) begin
      mm_mem[w]  = 32'h1000_0000 + w;
      ref_mem[w] = 32'h1000_0000 + w;
    end
    bus.imem_read = 1'b0; bus.imem_address = '0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0; bus.mem_writedata = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_umem_strobes", {bus.umem_read, bus.umem_write}, 2'b00);
    chk("rst_umem_addr", bus.umem_address, 0);
    chk("rst_umem_wdata", bus.umem_writedata, 0);
    chk("rst_imem_rdata", bus.imem_readdata, 0);
    chk("rst_mem_rdata", bus.mem_readdata, 0);
    chk("rst_busywaits", {bus.mem_busywait, bus.imem_busywait}, 2'b00);
    rst_n = 1'b1;
    ref_last = SRC_I;
    tick();

    // Ties: dcache first after reset, and again after the refill
    lat_n = 2;
    do_tie(6'h01, 6'h03);
    do_tie(6'h04, 6'h07);

    lat_n = 5;
    do_d(1'b0, 6'h05, 32'h0, 1'b1);
    do_i(6'h02, 1'b0);
    lat_n = 3;
    do_d(1'b1, 6'h3F, 32'hDEAD_BEEF, 1'b1);
    do_d(1'b0, 6'h3F, 32'h0, 1'b1);
    do_i(6'h09, 1'b1);

    // Reset in the middle of icache beat 2
    lat_n = 3;
    base = log_addr.size(); ok = 1'b0;
    bus.imem_read = 1'b1; bus.imem_address = 6'h05;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      if (log_addr.size() - base >= 3) ok = 1'b1;
    end
    chk("mid_rst_reach_beat2", ok, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_strobes", {bus.umem_read, bus.umem_write}, 2'b00);
    chk("mid_rst_addr", bus.umem_address, 0);
    chk("mid_rst_wdata", bus.umem_writedata, 0);
    chk("mid_rst_imem_rdata", bus.imem_readdata, 0);
    chk("mid_rst_ibusy", bus.imem_busywait, 1'b1);
    rst_n = 1'b1;
    ref_last = SRC_I;
    ref_drd = '0;
    do_i(6'h05, 1'b0);

    // Randomized mix
    for (int n = 0; n < 40; n++) begin
      int op;
      lat_n = $urandom_range(1, 4);
      op = $urandom_range(0, 3);
      case (op)
        0: do_d(1'b0, 6'($urandom_range(0, 63)), 32'h0, 1'b1);
        1: do_d(1'b1, 6'($urandom_range(0, 63)), $urandom, 1'b1);
        2: do_i(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        default: do_tie(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
